rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8.sv | 115 +++++++++++
 tb/tb_rr_arbiter8.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters sharing one 8:1 select path.
// Grants are registered, bounded to MAX_HOLD cycles unless locked, and separated by a dead cycle.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       lock,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
  localparam logic [7:0] HOLD_SAT   = 8'hFF;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] owner, owner_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic [7:0] grant_nxt;
  logic [2:0] sel_nxt;
  logic       valid_nxt;
  logic       preempt_nxt;

  // Rotate req so that bit 0 is the requester at ptr; the lowest set bit wins.
  logic [15:0] req_dbl;
  logic [7:0]  req_rot;
  logic [2:0]  win_off;
  logic [2:0]  winner;

  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[7:0];
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) win_off = 3'(i);
    end
    winner = ptr + win_off;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    owner_nxt   = owner;
    hold_nxt    = hold_cnt;
    grant_nxt   = grant;
    sel_nxt     = sel;
    valid_nxt   = valid;
    preempt_nxt = 1'b0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          owner_nxt = winner;
          grant_nxt = 8'b0000_0001 << winner;
          sel_nxt   = winner;
          valid_nxt = 1'b1;
          hold_nxt  = 8'd1;
        end else begin
          grant_nxt = 8'd0;
          valid_nxt = 1'b0;
        end
      end

      GRANT: begin
        // >= also revokes an owner whose count ran past the limit while it was locked.
        if (!req[owner] || (!lock && hold_cnt >= HOLD_LIMIT)) begin
          state_nxt   = IDLE;
          grant_nxt   = 8'd0;
          valid_nxt   = 1'b0;
          ptr_nxt     = owner + 3'd1;
          preempt_nxt = req[owner];
        end else if (hold_cnt != HOLD_SAT) begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      owner    <= 3'd0;
      hold_cnt <= 8'd0;
      grant    <= 8'd0;
      sel      <= 3'd0;
      valid    <= 1'b0;
      preempt  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      owner    <= owner_nxt;
      hold_cnt <= hold_nxt;
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      valid    <= valid_nxt;
      preempt  <= preempt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus a random run
// compared cycle by cycle against a behavioural round-robin model.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;
  localparam int STARVE_LIMIT = 8 * (MAX_HOLD + 1);

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic       lock;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic       preempt;

  int errors;
  int checks;

  // Behavioural model: owner index or -1 when nobody holds the path.
  int m_owner;
  int m_ptr;
  int m_hold;
  int m_sel;
  bit m_preempt;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .lock    (lock),
    .grant   (grant),
    .sel     (sel),
    .valid   (valid),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_grant();
    return (m_owner < 0) ? 8'd0 : 8'(1 << m_owner);
  endfunction

  task automatic model_update();
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_preempt = 0;
    end else if (m_owner < 0) begin
      m_preempt = 0;
      for (int k = 0; k < 8; k++) begin
        int idx;
        idx = (m_ptr + k) % 8;
        if (req[idx]) begin
          m_owner = idx; m_sel = idx; m_hold = 1;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_preempt = 0;
    end else if (!lock && m_hold >= MAX_HOLD) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_preempt = 1;
    end else begin
      m_hold = (m_hold < 255) ? m_hold + 1 : 255;
    end
  endtask

  // One clock: model consumes the pre-edge inputs, outputs are sampled 1ns after the edge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 8'd0; lock = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 8'hFF; lock = 1'b1;
    step();
    checks++;
    if (grant !== 8'd0 || sel !== 3'd0 || valid !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant=%h sel=%0d valid=%b preempt=%b, want 00/0/0/0",
               grant, sel, valid, preempt);
    end
    reset = 1'b0; req = 8'd0; lock = 1'b0;
    step();
    checks++;
    if (grant !== 8'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: grant=%h valid=%b, want 00/0", grant, valid);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    req = 8'b1000_0001;
    for (int c = 1; c <= MAX_HOLD; c++) begin
      step();
      checks++;
      if (grant !== 8'h01 || sel !== 3'd0 || valid !== 1'b1 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL preempt_hold c%0d: grant=%h sel=%0d valid=%b preempt=%b, want 01/0/1/0",
                 c, grant, sel, valid, preempt);
      end
    end
    step();
    checks++;
    if (grant !== 8'd0 || valid !== 1'b0 || preempt !== 1'b1) begin
      errors++;
      $display("FAIL preempt_pulse: grant=%h valid=%b preempt=%b, want 00/0/1", grant, valid, preempt);
    end
    step();
    checks++;
    if (grant !== 8'h80 || sel !== 3'd7 || valid !== 1'b1 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL preempt_next: grant=%h sel=%0d valid=%b preempt=%b, want 80/7/1/0",
               grant, sel, valid, preempt);
    end
  endtask

  // Continues from owner 7 left by test_preempt.
  task automatic test_wrap();
    req = 8'h03;
    step();
    checks++;
    if (grant !== 8'd0 || valid !== 1'b0 || preempt !== 1'b0 || sel !== 3'd7) begin
      errors++;
      $display("FAIL wrap_release: grant=%h valid=%b preempt=%b sel=%0d, want 00/0/0/7",
               grant, valid, preempt, sel);
    end
    step();
    checks++;
    if (grant !== 8'h01 || sel !== 3'd0) begin
      errors++;
      $display("FAIL wrap_grant: grant=%h sel=%0d, want 01/0", grant, sel);
    end
    req = 8'd0;
    step();
    step();
  endtask

  task automatic test_lock();
    do_reset();
    req = 8'h04; lock = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      req = 8'hFF;
      checks++;
      if (grant !== 8'h04 || sel !== 3'd2 || preempt !== 1'b0) begin
        errors++;
        $display("FAIL lock_hold c%0d: grant=%h sel=%0d preempt=%b, want 04/2/0",
                 c, grant, sel, preempt);
      end
    end
    req = 8'd0; lock = 1'b0;
    step();
    step();
  endtask

  task automatic test_drop_at_max();
    do_reset();
    req = 8'h08;
    for (int c = 1; c <= MAX_HOLD; c++) step();
    checks++;
    if (grant !== 8'h08) begin
      errors++;
      $display("FAIL drop_pre: grant=%h, want 08", grant);
    end
    req = 8'h11;
    step();
    checks++;
    if (grant !== 8'd0 || valid !== 1'b0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL drop_release: grant=%h valid=%b preempt=%b, want 00/0/0", grant, valid, preempt);
    end
    step();
    checks++;
    if (grant !== 8'h10 || sel !== 3'd4) begin
      errors++;
      $display("FAIL drop_ptr: grant=%h sel=%0d, want 10/4", grant, sel);
    end
    req = 8'd0;
    step();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h20;
    step();
    step();
    checks++;
    if (grant !== 8'h20 || sel !== 3'd5) begin
      errors++;
      $display("FAIL midrst_pre: grant=%h sel=%0d, want 20/5", grant, sel);
    end
    reset = 1'b1; req = 8'hFF;
    step();
    checks++;
    if (grant !== 8'd0 || valid !== 1'b0 || sel !== 3'd0 || preempt !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear: grant=%h valid=%b sel=%0d preempt=%b, want 00/0/0/0",
               grant, valid, sel, preempt);
    end
    reset = 1'b0;
    step();
    checks++;
    if (grant !== 8'h01 || sel !== 3'd0) begin
      errors++;
      $display("FAIL midrst_next: grant=%h sel=%0d, want 01/0", grant, sel);
    end
    req = 8'd0;
    step();
  endtask

  task automatic test_random();
    int         wait_cnt[8];
    logic [7:0] prev_grant;
    do_reset();
    prev_grant = 8'd0;
    for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [7:0] r;
      bit         starved;
      r = req;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      req  = r;
      lock = ($urandom_range(0, 19) == 0);
      step();

      checks++;
      if (grant !== m_grant() || valid !== (m_owner >= 0) || preempt !== m_preempt ||
          sel !== 3'(m_sel)) begin
        errors++;
        $display("FAIL rand_model cyc%0d: grant=%h sel=%0d valid=%b preempt=%b, want %h/%0d/%b/%b",
                 cyc, grant, sel, valid, preempt, m_grant(), m_sel, (m_owner >= 0), m_preempt);
      end

      checks++;
      if ($countones(grant) > 1 || valid !== (grant != 8'd0) ||
          (valid && grant !== (8'd1 << sel)) ||
          (prev_grant != 8'd0 && grant != 8'd0 && grant != prev_grant)) begin
        errors++;
        $display("FAIL rand_struct cyc%0d: grant=%h prev=%h sel=%0d valid=%b",
                 cyc, grant, prev_grant, sel, valid);
      end
      prev_grant = grant;

      starved = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (lock || !req[i] || grant[i]) wait_cnt[i] = 0;
        else wait_cnt[i]++;
        if (wait_cnt[i] > STARVE_LIMIT) begin
          starved = 1'b1;
          wait_cnt[i] = 0;
        end
      end
      checks++;
      if (starved) begin
        errors++;
        $display("FAIL rand_starve cyc%0d: a requester waited more than %0d cycles", cyc, STARVE_LIMIT);
      end
    end
    req = 8'd0; lock = 1'b0;
    step();
    step();
  endtask

  initial begin
    errors = 0; checks = 0;
    m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_preempt = 0;
    reset = 1'b1; req = 8'd0; lock = 1'b0;
    #2;
    test_reset();
    test_preempt();
    test_wrap();
    test_lock();
    test_drop_at_max();
    test_reset_mid_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
